fsm_string_tx: RTL and testbench

- Serial frame transmitter; the transmit end of the 11011-sync serial bit protocol used by the string-detector FSMs.
- Accepts a parallel word over a valid/ready handshake and emits one serial frame: sync header 11011, then DATA_W payload bits MSB-first.
- Inserts stuffed 0 bits so that 11011 never appears anywhere except the header.
- Sits upstream of the serial link; downstream detectors fire exactly once per frame.

---
 rtl/fsm_string_pkg.sv | 26 ++
 rtl/fsm_string_tx.sv | 155 +++++++++++++++
 tb/tb_fsm_string_tx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_string_pkg.sv
// ============================================================================
// Module   : fsm_string_pkg
// Brief    : Shared constants for the 11011-sync serial string protocol:
//            FSM state encodings, sync header pattern and stuffing trigger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_string_pkg;

  // Transmitter FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STUFF = 2'd3;

  // Sync header, sent MSB (index SYNC_LEN-1) first
  localparam logic [4:0] SYNC_PAT = 5'b11011;
  localparam int         SYNC_LEN = 5;

  // Last four line bits (newest in LSB) that force a stuffed 0 next
  localparam logic [3:0] STUFF_TRIG = 4'b1101;

endpackage : fsm_string_pkg

`default_nettype wire

// File: rtl/fsm_string_tx.sv
// ============================================================================
// Module   : fsm_string_tx
// Brief    : Serial frame transmitter. Accepts a parallel word over a
//            valid/ready handshake and emits header 11011 followed by the
//            payload MSB-first, inserting a 0 after every 1101 seen in the
//            payload region so 11011 only ever appears as the header.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_string_tx
  import fsm_string_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shift;     // payload bits not yet driven, next in MSB
  logic [CNT_W-1:0]  r_cnt;       // payload bits not yet driven
  logic [2:0]        r_hdr_idx;   // header index of the bit now on the line
  logic [3:0]        r_hist;      // last four consumed frame bits, newest LSB
  logic              r_bit;
  logic              r_bit_valid;
  logic              r_ready;
  logic              r_start;
  logic              r_done;

  logic [3:0] w_hist_nx;
  logic [2:0] w_hdr_nx;
  logic       w_remain;

  // History after consuming the current line bit, and derived helpers
  always_comb begin
    w_hist_nx = {r_hist[2:0], r_bit};
    w_hdr_nx  = r_hdr_idx - 3'd1;
    w_remain  = (r_cnt != '0);
  end

  // Frame sequencer: header, payload with stuffing, then back to idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hdr_idx   <= '0;
      r_hist      <= '0;
      r_bit       <= IDLE_BIT;
      r_bit_valid <= 1'b0;
      r_ready     <= 1'b1;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_state     <= ST_SYNC;
            r_shift     <= tx_data;
            r_cnt       <= CNT_W'(DATA_W);
            r_hdr_idx   <= 3'(SYNC_LEN - 1);
            r_hist      <= '0;
            r_bit       <= SYNC_PAT[SYNC_LEN-1];
            r_bit_valid <= 1'b1;
            r_ready     <= 1'b0;
            r_start     <= 1'b1;
          end
        end

        ST_SYNC: begin
          if (bit_en) begin
            r_hist <= w_hist_nx;
            if (r_hdr_idx == 3'd0) begin
              // Header complete: first payload bit follows directly
              r_state <= ST_DATA;
              r_bit   <= r_shift[DATA_W-1];
              r_shift <= r_shift << 1;
              r_cnt   <= r_cnt - 1'b1;
            end else begin
              r_hdr_idx <= w_hdr_nx;
              r_bit     <= SYNC_PAT[w_hdr_nx];
            end
          end
        end

        ST_DATA: begin
          if (bit_en) begin
            r_hist <= w_hist_nx;
            if (w_hist_nx == STUFF_TRIG) begin
              // Break a potential 11011 before it can form
              r_state <= ST_STUFF;
              r_bit   <= 1'b0;
            end else if (w_remain) begin
              r_bit   <= r_shift[DATA_W-1];
              r_shift <= r_shift << 1;
              r_cnt   <= r_cnt - 1'b1;
            end else begin
              r_state     <= ST_IDLE;
              r_bit       <= IDLE_BIT;
              r_bit_valid <= 1'b0;
              r_ready     <= 1'b1;
              r_done      <= 1'b1;
            end
          end
        end

        ST_STUFF: begin
          if (bit_en) begin
            r_hist <= w_hist_nx;
            if (w_remain) begin
              r_state <= ST_DATA;
              r_bit   <= r_shift[DATA_W-1];
              r_shift <= r_shift << 1;
              r_cnt   <= r_cnt - 1'b1;
            end else begin
              // Trailing stuff bit was the last bit of the frame
              r_state     <= ST_IDLE;
              r_bit       <= IDLE_BIT;
              r_bit_valid <= 1'b0;
              r_ready     <= 1'b1;
              r_done      <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = r_ready;
  assign bit_out     = r_bit;
  assign bit_valid   = r_bit_valid;
  assign frame_start = r_start;
  assign frame_done  = r_done;

endmodule : fsm_string_tx

`default_nettype wire

// File: tb/tb_fsm_string_tx.sv
// ============================================================================
// Module   : tb_fsm_string_tx
// Brief    : Self-checking bench for fsm_string_tx. Accepted words are
//            expanded into expected line bits by a stream-level model and
//            queued; a monitor pops and compares every consumed bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_string_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          bit_en = 1'b1;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_ready;
  logic          bit_out;
  logic          bit_valid;
  logic          frame_start;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  bit exp_q[$];
  bit frm[$];
  int acc_cnt       = 0;
  bit pending_start = 1'b0;
  bit hold_pend     = 1'b0;
  bit hold_bit      = 1'b0;
  int en_mode       = 0;
  int en_low        = 0;

  fsm_string_tx #(
    .DATA_W   (DW),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_en      (bit_en),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  // Expected line stream: header, then payload MSB-first; whenever the
  // stream so far ends in 1101 right after a payload bit, a 0 is inserted.
  function automatic void model_push(input logic [DW-1:0] d);
    bit s[$];
    int n;
    s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = DW - 1; i >= 0; i--) begin
      s.push_back(d[i]);
      n = s.size();
      if (s[n-4] && s[n-3] && !s[n-2] && s[n-1]) s.push_back(1'b0);
    end
    foreach (s[k]) exp_q.push_back(s[k]);
  endfunction

  function automatic int count_sync();
    int c = 0;
    for (int i = 0; i + 4 < frm.size(); i++)
      if (frm[i] && frm[i+1] && !frm[i+2] && frm[i+3] && frm[i+4]) c++;
    return c;
  endfunction

  // Monitor: samples mid-cycle, ahead of the edge that consumes the bit
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_bit_out", bit_out, 0);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_start_done", {frame_start, frame_done}, 0);
      exp_q.delete();
      frm.delete();
      pending_start = 1'b0;
      hold_pend     = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_bit_out", bit_out, hold_bit);
        chk("hold_bit_valid", bit_valid, 1);
      end
      chk("frame_start", frame_start, pending_start);
      pending_start = 1'b0;
      chk("ready_vs_valid", tx_ready, !bit_valid);
      if (frame_done) begin
        chk("done_gap_valid", bit_valid, 0);
        chk("done_exp_left", exp_q.size(), 0);
        chk("sync_matches", count_sync(), 1);
        frm.delete();
      end
      hold_pend = 1'b0;
      if (bit_valid) begin
        if (bit_en) begin
          if (exp_q.size() == 0) begin
            chk("extra_bit", 1, 0);
          end else begin
            chk("line_bit", bit_out, exp_q.pop_front());
          end
          frm.push_back(bit_out);
        end else begin
          hold_pend = 1'b1;
          hold_bit  = bit_out;
        end
      end
      if (tx_ready && tx_valid) begin
        model_push(tx_data);
        pending_start = 1'b1;
        acc_cnt++;
      end
    end
  end

  // bit_en driver: forced-low window, random, or always on
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (en_low > 0) begin
        bit_en = 1'b0;
        en_low--;
      end else if (en_mode != 0) begin
        bit_en = ($urandom_range(0, 3) != 0);
      end else begin
        bit_en = 1'b1;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int start;
    bit ok;
    start    = acc_cnt;
    ok       = 1'b0;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (acc_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 1, 0);
    #1;
    tx_valid = 1'b0;
    tx_data  = DW'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bit_valid && tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int start;
    bit ok;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Directed frames with bit_en held high
    send(8'h00); wait_idle();
    send(8'hA5); wait_idle();
    send(8'hDB); wait_idle();

    // 8'hFF with tx_valid held and tx_data churning during the frame;
    // the next word goes out back-to-back once the block is ready again
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    start    = acc_cnt;
    ok       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt >= start + 2) begin
        ok = 1'b1;
        break;
      end
      if (acc_cnt == start + 1) tx_data = DW'($urandom);
    end
    if (!ok) chk("b2b_timeout", 1, 0);
    tx_valid = 1'b0;
    wait_idle();

    // Three-cycle bit_en stall in the payload
    send(8'h96);
    repeat (8) @(posedge clk);
    en_low = 3;
    wait_idle();

    // Random words with random bit_en and idle gaps
    en_mode = 1;
    for (int n = 0; n < 24; n++) begin
      send(DW'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    en_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of the payload
    send(8'hC3);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_bit_out", bit_out, 0);
    chk("async_bit_valid", bit_valid, 0);
    chk("async_tx_ready", tx_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    send(8'h00); wait_idle();

    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fsm_string_tx

`default_nettype wire
